// File: rtl/spk_event_packer.sv
`default_nettype none
// ============================================================================
// Module   : spk_event_packer
// Brief    : Timestamps detected spike peaks with the running frame number,
//            queues them in a FIFO and emits each one as a 3-word packet.
// Revision : 1.0  initial release
// ============================================================================
module spk_event_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pack_enable,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [7:0]                    ch_in,
    input  logic [31:0]                   ch_unigroup_in,
    input  logic [31:0]                   v_in,
    input  logic                          is_peak_in,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [31:0]                   m_data,
    output logic                          m_last,
    output logic [31:0]                   frame_no,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = 95;
    // Entry layout: {frame[94:63], unigroup[31:8] at [62:39], ch[38:31], v[31:1] at [30:0]}
    localparam int c_FRM_LSB = 63;
    localparam int c_UG_LSB  = 39;
    localparam int c_CH_LSB  = 31;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [31:0]           r_m_data;
    logic [31:0]           r_frame;
    logic [CNT_W-1:0]      r_drop;
    logic [c_CW-1:0]       r_count;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_EW-1:0]       r_mem [FIFO_DEPTH];

    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_push_ok;
    logic [c_EW-1:0]       w_push_ent;
    logic [c_EW-1:0]       w_head;
    logic [c_EW-1:0]       w_next_head;
    logic [c_AW-1:0]       w_rd_ptr_inc;
    logic [c_CW-1:0]       w_count_next;
    logic                  w_unused;

    assign w_push_req   = valid_in & is_peak_in & pack_enable;
    assign w_pop        = r_m_valid & m_ready & (r_state == W2);
    assign w_push_ok    = w_push_req & ((r_count < c_DEPTH) | w_pop);
    assign w_push_ent   = {r_frame, ch_unigroup_in[31:8], ch_in, v_in[31:1]};
    assign w_rd_ptr_inc = r_rd_ptr + c_AW'(1);
    assign w_head       = r_mem[r_rd_ptr];
    // With a single entry left, the follow-on head is the entry being written this edge.
    assign w_next_head  = (r_count == c_ONE) ? w_push_ent : r_mem[w_rd_ptr_inc];
    assign w_count_next = r_count + c_CW'(w_push_ok) - c_CW'(w_pop);
    assign w_unused     = &{1'b0, v_in[0], ch_unigroup_in[7:0]};

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_last     = r_m_last;
    assign frame_no   = r_frame;
    assign drop_cnt   = r_drop;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame  <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (valid_in && eof_in) begin
                r_frame <= r_frame + 32'd1;
            end
            if (w_push_req && !w_push_ok && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_state   <= W0;
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_head[c_EW-1:c_FRM_LSB];
                    end
                end
                W0: begin
                    if (m_ready) begin
                        r_state  <= W1;
                        r_m_data <= {w_head[c_FRM_LSB-1:c_UG_LSB], w_head[c_UG_LSB-1:c_CH_LSB]};
                    end
                end
                W1: begin
                    if (m_ready) begin
                        r_state  <= W2;
                        r_m_last <= 1'b1;
                        r_m_data <= {w_head[c_CH_LSB-1:0], 1'b1};
                    end
                end
                W2: begin
                    if (m_ready) begin
                        r_m_last <= 1'b0;
                        if (w_count_next != '0) begin
                            r_state  <= W0;
                            r_m_data <= w_next_head[c_EW-1:c_FRM_LSB];
                        end else begin
                            r_state   <= IDLE;
                            r_m_valid <= 1'b0;
                            r_m_data  <= '0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spk_event_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spk_event_packer
// Brief    : Self-checking bench for spk_event_packer against an event-queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spk_event_packer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pack_enable;
    logic             valid_in;
    logic             eof_in;
    logic [7:0]       ch_in;
    logic [31:0]      ch_unigroup_in;
    logic [31:0]      v_in;
    logic             is_peak_in;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;
    logic [31:0]      frame_no;
    logic [CNT_W-1:0] drop_cnt;
    logic [CW-1:0]    fifo_count;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] ug;
        logic [7:0]  ch;
        logic [31:0] v;
    } ev_t;

    ev_t              mq[$];
    logic [31:0]      acc_words[$];
    int               widx;
    logic [31:0]      m_frame;
    logic [CNT_W-1:0] m_drop;
    int               n_vec = 0;
    int               n_fail = 0;

    spk_event_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pack_enable(pack_enable), .valid_in(valid_in),
        .eof_in(eof_in), .ch_in(ch_in), .ch_unigroup_in(ch_unigroup_in), .v_in(v_in),
        .is_peak_in(is_peak_in), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_no(frame_no), .drop_cnt(drop_cnt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(ev_t e, int idx);
        case (idx)
            0:       return e.frame;
            1:       return {e.ug[31:8], e.ch};
            default: return {e.v[31:1], 1'b1};
        endcase
    endfunction

    task automatic idle_inputs();
        valid_in = 0; eof_in = 0; is_peak_in = 0;
        ch_in = 0; ch_unigroup_in = 0; v_in = 0;
    endtask

    task automatic clear_model();
        mq.delete(); acc_words.delete();
        widx = 0; m_frame = 0; m_drop = 0;
    endtask

    task automatic drive_peak(logic [7:0] ch, logic [31:0] ug, logic [31:0] v);
        valid_in = 1; eof_in = 0; is_peak_in = 1;
        ch_in = ch; ch_unigroup_in = ug; v_in = v;
    endtask

    // One clock: update the model from pre-edge inputs/handshake, then check.
    task automatic step();
        int          cnt_prev;
        logic        pop, push_req, push_ok, stall, hold_last, exp_valid;
        logic [31:0] hold_data, exp;
        ev_t         ev;
        cnt_prev  = mq.size();
        pop       = 1'b0;
        stall     = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
        if (m_valid && m_ready) begin
            n_vec++;
            if (mq.size() == 0) begin
                n_fail++;
                $display("FAIL word: got %h with no event queued", m_data);
            end else begin
                exp = exp_word(mq[0], widx);
                if (m_data !== exp || m_last !== (widx == 2)) begin
                    n_fail++;
                    $display("FAIL word%0d: got data=%h last=%b, want data=%h last=%b",
                             widx, m_data, m_last, exp, (widx == 2));
                end
            end
            acc_words.push_back(m_data);
            if (widx == 2) begin widx = 0; pop = 1'b1; end
            else widx++;
        end
        push_req = valid_in && is_peak_in && pack_enable;
        push_ok  = push_req && (cnt_prev < DEPTH || pop);
        ev.frame = m_frame; ev.ug = ch_unigroup_in; ev.ch = ch_in; ev.v = v_in;
        if (valid_in && eof_in) m_frame = m_frame + 1;
        if (push_req && !push_ok && m_drop != '1) m_drop = m_drop + 1;
        @(posedge clk); #1;
        if (pop && mq.size() != 0) void'(mq.pop_front());
        if (push_ok) mq.push_back(ev);
        exp_valid = (mq.size() != 0) && (cnt_prev != 0);
        n_vec++;
        if (fifo_count !== CW'(mq.size()) || drop_cnt !== m_drop || frame_no !== m_frame) begin
            n_fail++;
            $display("FAIL counters: got count=%0d drop=%0d frame=%0d, want count=%0d drop=%0d frame=%0d",
                     fifo_count, drop_cnt, frame_no, mq.size(), m_drop, m_frame);
        end
        n_vec++;
        if (m_valid !== exp_valid || (!m_valid && m_last)) begin
            n_fail++;
            $display("FAIL valid: got valid=%b last=%b, want valid=%b", m_valid, m_last, exp_valid);
        end
        if (stall) begin
            n_vec++;
            if (m_data !== hold_data || m_last !== hold_last) begin
                n_fail++;
                $display("FAIL stall_hold: got %h/%b, want %h/%b", m_data, m_last, hold_data, hold_last);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        idle_inputs();
        m_ready = 1;
        while ((mq.size() != 0 || m_valid) && n < 300) begin
            step();
            n++;
        end
        n_vec++;
        if (mq.size() != 0 || m_valid) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d events left, want 0", mq.size());
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        pack_enable = 1; m_ready = 1;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (m_valid !== 0 || m_last !== 0 || m_data !== 0 || frame_no !== 0 ||
            drop_cnt !== 0 || fifo_count !== 0) begin
            n_fail++;
            $display("FAIL reset: got v=%b l=%b d=%h f=%0d drop=%0d cnt=%0d, want all zero",
                     m_valid, m_last, m_data, frame_no, drop_cnt, fifo_count);
        end
    endtask

    task automatic test_single_peak();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid_in = 1; eof_in = 1;
            step();
        end
        idle_inputs();
        drive_peak(8'd3, 32'hAABBCC01, 32'hFFFFF801);
        step();
        idle_inputs();
        n_vec++;
        if (fifo_count !== 1 || m_valid !== 0) begin
            n_fail++;
            $display("FAIL single_push: got count=%0d valid=%b, want 1/0", fifo_count, m_valid);
        end
        step();
        n_vec++;
        if (m_valid !== 1 || m_data !== 32'h00000005 || m_last !== 0) begin
            n_fail++;
            $display("FAIL single_w0: got %b/%h/%b, want 1/00000005/0", m_valid, m_data, m_last);
        end
        step();
        n_vec++;
        if (m_data !== 32'hAABBCC03 || m_last !== 0) begin
            n_fail++;
            $display("FAIL single_w1: got %h/%b, want aabbcc03/0", m_data, m_last);
        end
        step();
        n_vec++;
        if (m_data !== 32'hFFFFF801 || m_last !== 1) begin
            n_fail++;
            $display("FAIL single_w2: got %h/%b, want fffff801/1", m_data, m_last);
        end
        step();
        n_vec++;
        if (fifo_count !== 0 || m_valid !== 0 || acc_words.size() != 3) begin
            n_fail++;
            $display("FAIL single_end: got count=%0d valid=%b words=%0d, want 0/0/3",
                     fifo_count, m_valid, acc_words.size());
        end
    endtask

    task automatic test_frames();
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 32; c++) begin
                valid_in = 1; ch_in = 8'(c); eof_in = (c == 31);
                is_peak_in = (f == 0 && c == 31);
                ch_unigroup_in = $urandom; v_in = $urandom | 32'h1;
                step();
            end
        end
        idle_inputs();
        drive_peak(8'd7, $urandom, $urandom | 32'h1);
        step();
        drain();
        n_vec++;
        if (acc_words.size() != 6 || acc_words[0] !== 32'd0 || acc_words[3] !== 32'd4 || frame_no !== 32'd4) begin
            n_fail++;
            $display("FAIL frames: got words=%0d eofW0=%h W0=%h frame=%0d, want 6/0/4/4",
                     acc_words.size(), acc_words[0], acc_words[3], frame_no);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want [6];
        int n = 0;
        want = '{32'h0, 32'hDEADBE21, 32'h12345679, 32'h0, 32'h0BADF042, 32'h80000001};
        do_reset();
        m_ready = 0;
        drive_peak(8'h21, 32'hDEADBE00, 32'h12345679); step();
        drive_peak(8'h42, 32'h0BADF0FF, 32'h80000000); step();
        idle_inputs();
        while (acc_words.size() < 6 && n < 60) begin
            m_ready = (n % 2 == 0);
            step();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= acc_words.size() || acc_words[i] !== want[i]) begin
                n_fail++;
                $display("FAIL backpressure_word%0d: got %h, want %h", i,
                         (i < acc_words.size()) ? acc_words[i] : 32'hx, want[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_peak(8'(i), $urandom, $urandom);
            step();
        end
        idle_inputs();
        step();
        m_ready = 1;
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (m_valid !== 1) begin
                n_fail++;
                $display("FAIL back_to_back_gap: cycle %0d got valid=%b, want 1", i, m_valid);
            end
            step();
        end
        n_vec++;
        if (fifo_count !== 0 || acc_words.size() != 9) begin
            n_fail++;
            $display("FAIL back_to_back_end: got count=%0d words=%0d, want 0/9", fifo_count, acc_words.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        m_ready = 0;
        for (int i = 0; i < 20; i++) begin
            drive_peak(8'(i), $urandom, $urandom);
            step();
        end
        idle_inputs();
        n_vec++;
        if (fifo_count !== 16 || drop_cnt !== 4) begin
            n_fail++;
            $display("FAIL full: got count=%0d drop=%0d, want 16/4", fifo_count, drop_cnt);
        end
        drain();
        n_vec++;
        if (acc_words.size() != 48) begin
            n_fail++;
            $display("FAIL full_drain: got %0d words, want 48", acc_words.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_vec++;
                if (acc_words[3*i+1][7:0] !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL full_order%0d: got ch %0d, want %0d", i, acc_words[3*i+1][7:0], i);
                end
            end
        end
    endtask

    task automatic test_full_simul();
        int n = 0;
        do_reset();
        m_ready = 0;
        for (int i = 0; i < 16; i++) begin
            drive_peak(8'(i), $urandom, $urandom);
            step();
        end
        idle_inputs();
        step();
        m_ready = 1;
        while (m_last !== 1 && n < 10) begin
            step();
            n++;
        end
        n_vec++;
        if (m_last !== 1) begin
            n_fail++;
            $display("FAIL simul_reach_w2: got last=%b, want 1", m_last);
        end
        drive_peak(8'hEE, $urandom, $urandom);
        step();
        idle_inputs();
        n_vec++;
        if (fifo_count !== 16 || drop_cnt !== 0) begin
            n_fail++;
            $display("FAIL simul_push_pop: got count=%0d drop=%0d, want 16/0", fifo_count, drop_cnt);
        end
        drain();
        n_vec++;
        if (acc_words.size() != 51 || acc_words[49][7:0] !== 8'hEE) begin
            n_fail++;
            $display("FAIL simul_drain: got %0d words, want 51 ending with ch ee", acc_words.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_peak(8'(i + 1), $urandom, $urandom);
            step();
        end
        idle_inputs();
        step();
        m_ready = 1;
        step();
        n_vec++;
        if (m_valid !== 1 || m_last !== 0 || fifo_count !== 3) begin
            n_fail++;
            $display("FAIL reset_mid_w1: got v=%b l=%b cnt=%0d, want 1/0/3", m_valid, m_last, fifo_count);
        end
        #2 rst = 1;
        #1;
        n_vec++;
        if (m_valid !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got valid=%b, want 0", m_valid);
        end
        clear_model();
        @(posedge clk); #1;
        rst = 0;
        n_vec++;
        if (fifo_count !== 0 || frame_no !== 0 || drop_cnt !== 0 || m_valid !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got cnt=%0d frame=%0d drop=%0d v=%b, want zeros",
                     fifo_count, frame_no, drop_cnt, m_valid);
        end
        drive_peak(8'h55, 32'h12345600, 32'h00000010);
        step();
        drain();
        n_vec++;
        if (acc_words.size() != 3 || acc_words[0] !== 32'h0 || acc_words[1] !== 32'h12345655 ||
            acc_words[2] !== 32'h00000011) begin
            n_fail++;
            $display("FAIL reset_mid_packet: got %0d words, want 00000000 12345655 00000011", acc_words.size());
        end
    endtask

    task automatic test_random();
        int ready_pct;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) ready_pct = $urandom_range(10, 100);
            pack_enable    = ($urandom_range(0, 9) != 0);
            valid_in       = ($urandom_range(0, 3) != 0);
            eof_in         = ($urandom_range(0, 15) == 0);
            is_peak_in     = ($urandom_range(0, 2) == 0);
            ch_in          = 8'($urandom);
            ch_unigroup_in = $urandom;
            v_in           = $urandom;
            m_ready        = ($urandom_range(1, 100) <= ready_pct);
            step();
        end
        pack_enable = 1;
        drain();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        pack_enable = 1; m_ready = 1; rst = 1;
        clear_model();
        test_reset();
        test_single_peak();
        test_frames();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spk_event_packer.md
Name: spk_event_packer

Overview:
- Consumes the per-sample output stream of the spike-detection stage: valid, channel, unigroup hash, 32-bit sample whose LSB is the peak flag, end-of-frame.
- Timestamps every detected peak with a running frame number and buffers the event in a small FIFO.
- Serialises each buffered event as a 3-word packet over a valid/ready interface toward the host FIFO, with drop accounting.

Parameters:
FIFO_DEPTH, 16, event FIFO entries; power of two, 2..256
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pack_enable  in  1  1 = accept new events; 0 = ignore peaks; packet in flight still completes
valid_in  in  1  sample strobe from detector
eof_in  in  1  last channel sample of current frame
ch_in  in  8  channel number
ch_unigroup_in  in  32  hash: [7:0] streamNo, [31:8] nearest electrodes
v_in  in  32  signed sample; bit0 = peak flag
is_peak_in  in  1  peak qualifier (peak flag AND valid)
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  32  packet word
m_last  out  1  high on third word of packet
frame_no  out  32  current frame counter
drop_cnt  out  CNT_W  events lost to FIFO full, saturating
fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync release): frame_no=0, drop_cnt=0, FIFO empty, fifo_count=0, state IDLE, m_valid=0, m_last=0, m_data=0.
- Frame counter: +1 at edge where valid_in && eof_in; wraps 2^32-1 -> 0. The eof sample itself carries the pre-increment value.
- Push: valid_in && is_peak_in && pack_enable. Entry = {frame_no, ch_unigroup_in[31:8], ch_in, v_in[31:1]} (95 bits). Peak with valid_in=0 is ignored.
- Pop: occurs at the edge where the W2 word is accepted (m_valid && m_ready && state==W2).
- Full handling:
  - Push accepted if fifo_count<FIFO_DEPTH, or a pop occurs on the same edge.
  - Otherwise the event is dropped and drop_cnt increments, saturating at all-ones.
  - fifo_count_next = fifo_count + push_accepted - pop.
- FSM states: IDLE, W0, W1, W2. m_valid = (state != IDLE).
  - IDLE -> W0 when fifo_count != 0 (registered count).
  - W0 -> W1 and W1 -> W2 on m_ready.
  - W2 on m_ready: -> W0 if fifo_count-1+push_accepted != 0, else -> IDLE.
  - No advance while m_ready=0; m_data and m_last hold stable.
- Packet words, all from FIFO head:
  - W0 = frame_no.
  - W1 = {unigroup[31:8], ch}.
  - W2 = {v[31:1], 1'b1}.
  - m_last=1 only in W2.
- Latency: push at edge k -> fifo_count=1 after k -> m_valid=1 after edge k+1 (2 cycles). Back-to-back packets need no idle cycle.
- pack_enable low mid-packet: current and queued packets still drain; only new pushes are blocked.
- Reset mid-packet: packet is abandoned; no partial continuation after release.
- Throughput: 1 word/clk under m_ready=1; sustained peak rate above 1 per 3 clocks fills the FIFO.

Test Plan:
- Single peak, m_ready=1, frame_no=5, ch=3, unigroup=0xAABBCC01, v=0xFFFFF801 -> 2 cycles later 3 words 0x00000005, 0xAABBCC03, 0xFFFFF801; m_last on the third word only; fifo_count returns to 0.
- 4 frames of 32 samples with eof on ch 31, then peak on ch 7 -> W0=0x00000004; the eof sample's own peak carries the pre-increment frame number.
- m_ready toggled 1010..., two queued events -> m_data/m_last stable while stalled; 6 words in order; no gap between packets when m_ready=1.
- m_ready=0, 20 consecutive peaks, FIFO_DEPTH=16 -> fifo_count=16, drop_cnt=4; releasing m_ready yields 16 packets, oldest first.
- FIFO full with state W2, m_ready=1, simultaneous new peak -> pop and push on the same edge, drop_cnt unchanged, fifo_count stays 16.
- rst asserted during W1 with 3 events queued -> m_valid=0 immediately; after release fifo_count=0, frame_no=0, drop_cnt=0; next peak produces a clean full packet.
